// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: command-master FSM states and response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP,
    DRAIN
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI-Lite master executing one read/write command at a time, answering on rsp_*.
// Optional watchdog with late-handshake drain: define AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, b_pend_q, b_pend_d;
  logic              ar_pend_q, ar_pend_d, r_pend_q, r_pend_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // Each *_pend flag tracks one AXI channel still owed a handshake; VALIDs come straight from them.
  assign cmd_ready = (state_q == IDLE) && !ARESET;
  assign AWVALID   = aw_pend_q;
  assign AWADDR    = addr_q;
  assign WVALID    = w_pend_q;
  assign WDATA     = wdata_q;
  assign ARVALID   = ar_pend_q;
  assign ARADDR    = addr_q;
  assign BREADY    = (state_q == WR_RESP) || ((state_q == DRAIN) && b_pend_q);
  assign RREADY    = (state_q == RD_RESP) || ((state_q == DRAIN) && r_pend_q);
  assign rsp_valid = (state_q == RSP);
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  assign aw_hs = aw_pend_q && AWREADY;
  assign w_hs  = w_pend_q && WREADY;
  assign b_hs  = BREADY && BVALID;
  assign ar_hs = ar_pend_q && ARREADY;
  assign r_hs  = RREADY && RVALID;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    aw_pend_d   = aw_pend_q && !aw_hs;
    w_pend_d    = w_pend_q && !w_hs;
    b_pend_d    = b_pend_q && !b_hs;
    ar_pend_d   = ar_pend_q && !ar_hs;
    r_pend_d    = r_pend_q && !r_hs;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            b_pend_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            ar_pend_d = 1'b1;
            r_pend_d  = 1'b1;
            state_d   = RD_REQ;
          end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      WR_REQ: if (!aw_pend_d && !w_pend_d) state_d = WR_RESP;
      WR_RESP: begin
        if (BVALID) begin
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD_REQ: if (!ar_pend_d) state_d = RD_RESP;
      RD_RESP: begin
        if (RVALID) begin
          rsp_resp_d  = RRESP;
          rsp_rdata_d = RDATA;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
          if (tmo_q) state_d = DRAIN;
          tmo_d = 1'b0;
`endif
        end
      end
      DRAIN: begin
        if (!aw_pend_d && !w_pend_d && !b_pend_d && !ar_pend_d && !r_pend_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // Timeout overrides the wait state; pending channels keep their VALIDs until DRAIN finishes them.
    if (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) begin
      if (aw_hs || w_hs || b_hs || ar_hs || r_hs) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = RSP;
        rsp_resp_d  = RESP_SLVERR;
        rsp_rdata_d = '0;
        tmo_d       = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      b_pend_q    <= 1'b0;
      ar_pend_q   <= 1'b0;
      r_pend_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      b_pend_q    <= b_pend_d;
      ar_pend_q   <= ar_pend_d;
      r_pend_q    <= r_pend_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`endif

endmodule
